// File: rtl/burst_expand.sv
// Expands {burst_len, base_addr} descriptors into one beat address per cycle.
// Optional addr_last output is enabled by defining BURST_EXPAND_LAST_EN.
module burst_expand #(
  parameter int unsigned AddrWidth         = 64,
  parameter int unsigned DataWidthBytesLog = 6,
  parameter int unsigned BurstLenWidth     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BurstLenWidth+AddrWidth-1:0] burst_dout,
  input  logic                               burst_empty_n,
  output logic                               burst_read,
  output logic [AddrWidth-1:0]               addr_din,
  input  logic                               addr_full_n,
  output logic                               addr_write
`ifdef BURST_EXPAND_LAST_EN
  ,
  output logic                               addr_last
`endif
);

  typedef enum logic {IDLE, EMIT} state_e;

  localparam logic [AddrWidth-1:0] Stride = AddrWidth'(1) << DataWidthBytesLog;

  state_e                   state_q, state_d;
  logic [AddrWidth-1:0]     cur_addr_q, cur_addr_d;
  logic [BurstLenWidth-1:0] remaining_q, remaining_d;

  logic [AddrWidth-1:0]     desc_base;
  logic [BurstLenWidth-1:0] desc_len;
  logic                     last_beat;

  assign desc_base = burst_dout[AddrWidth-1:0];
  assign desc_len  = burst_dout[AddrWidth +: BurstLenWidth];
  assign last_beat = (remaining_q == '0);
  assign addr_din  = cur_addr_q;

`ifdef BURST_EXPAND_LAST_EN
  assign addr_last = (state_q == EMIT) && last_beat;
`endif

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    burst_read  = 1'b0;
    addr_write  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          burst_read = burst_empty_n;
          if (burst_empty_n) begin
            cur_addr_d  = desc_base;
            remaining_d = desc_len;
            state_d     = EMIT;
          end
        end
        EMIT: begin
          addr_write = addr_full_n;
          if (addr_full_n) begin
            if (!last_beat) begin
              cur_addr_d  = cur_addr_q + Stride;
              remaining_d = remaining_q - 1'b1;
            end else if (burst_empty_n) begin
              // Chain straight into the next descriptor so bursts run without a bubble.
              burst_read  = 1'b1;
              cur_addr_d  = desc_base;
              remaining_d = desc_len;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: tb/tb_burst_expand.sv
// Directed self-checking bench for burst_expand (64-bit addresses, 64-byte beats).
module tb_burst_expand;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] burst_dout;
  logic        burst_empty_n;
  logic        burst_read;
  logic [63:0] addr_din;
  logic        addr_full_n;
  logic        addr_write;
`ifdef BURST_EXPAND_LAST_EN
  logic        addr_last;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  burst_expand #(
    .AddrWidth        (64),
    .DataWidthBytesLog(6),
    .BurstLenWidth    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .burst_dout   (burst_dout),
    .burst_empty_n(burst_empty_n),
    .burst_read   (burst_read),
    .addr_din     (addr_din),
    .addr_full_n  (addr_full_n),
    .addr_write   (addr_write)
`ifdef BURST_EXPAND_LAST_EN
    ,
    .addr_last    (addr_last)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_last(input string tag, input logic exp);
`ifdef BURST_EXPAND_LAST_EN
    chk(tag, {63'd0, addr_last}, {63'd0, exp});
`endif
  endtask

  // Advance one clock; inputs are then updated 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned nwr;
    logic [63:0] exp_addr;

    rst = 1'b1; burst_empty_n = 1'b0; addr_full_n = 1'b1; burst_dout = '0;
    tick(); tick();
    burst_empty_n = 1'b1; burst_dout = {8'd3, 64'h1000};
    #1;
    chk("rst_read", {63'd0, burst_read}, 64'd0);
    chk("rst_write", {63'd0, addr_write}, 64'd0);
    chk("rst_addr", addr_din, 64'd0);
    chk_last("rst_last", 1'b0);

    // 1: single 4-beat burst
    tick();
    rst = 1'b0;
    #1;
    chk("t1_read", {63'd0, burst_read}, 64'd1);
    chk("t1_idle_write", {63'd0, addr_write}, 64'd0);
    tick();
    burst_empty_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t1_write", {63'd0, addr_write}, 64'd1);
      chk("t1_addr", addr_din, 64'h1000 + 64'(i) * 64'h40);
      chk("t1_noread", {63'd0, burst_read}, 64'd0);
      chk_last("t1_last", i == 3);
      tick();
    end
    #1;
    chk("t1_end_write", {63'd0, addr_write}, 64'd0);
    chk("t1_end_read", {63'd0, burst_read}, 64'd0);

    // 2: single beat
    burst_dout = {8'd0, 64'h2000}; burst_empty_n = 1'b1;
    #1;
    chk("t2_read", {63'd0, burst_read}, 64'd1);
    tick();
    burst_empty_n = 1'b0;
    #1;
    chk("t2_write", {63'd0, addr_write}, 64'd1);
    chk("t2_addr", addr_din, 64'h2000);
    chk_last("t2_last", 1'b1);
    tick();
    #1;
    chk("t2_nowrite", {63'd0, addr_write}, 64'd0);

    // 3: backpressure after the first beat
    burst_dout = {8'd2, 64'h0}; burst_empty_n = 1'b1;
    tick();
    burst_empty_n = 1'b0;
    #1;
    chk("t3_b0_write", {63'd0, addr_write}, 64'd1);
    chk("t3_b0_addr", addr_din, 64'h0);
    tick();
    addr_full_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_stall_write", {63'd0, addr_write}, 64'd0);
      chk("t3_stall_read", {63'd0, burst_read}, 64'd0);
      chk("t3_stall_addr", addr_din, 64'h40);
      tick();
    end
    addr_full_n = 1'b1;
    #1;
    chk("t3_b1_write", {63'd0, addr_write}, 64'd1);
    chk("t3_b1_addr", addr_din, 64'h40);
    tick();
    #1;
    chk("t3_b2_write", {63'd0, addr_write}, 64'd1);
    chk("t3_b2_addr", addr_din, 64'h80);
    chk_last("t3_b2_last", 1'b1);
    tick();
    #1;
    chk("t3_end_write", {63'd0, addr_write}, 64'd0);

    // 4: back-to-back descriptors
    burst_dout = {8'd1, 64'h100}; burst_empty_n = 1'b1;
    tick();
    burst_dout = {8'd0, 64'h800};
    #1;
    chk("t4_b0_addr", addr_din, 64'h100);
    chk("t4_b0_write", {63'd0, addr_write}, 64'd1);
    chk("t4_b0_noread", {63'd0, burst_read}, 64'd0);
    tick();
    #1;
    chk("t4_b1_addr", addr_din, 64'h140);
    chk("t4_b1_write", {63'd0, addr_write}, 64'd1);
    chk("t4_b1_read", {63'd0, burst_read}, 64'd1);
    tick();
    burst_empty_n = 1'b0;
    #1;
    chk("t4_b2_addr", addr_din, 64'h800);
    chk("t4_b2_write", {63'd0, addr_write}, 64'd1);
    chk("t4_b2_noread", {63'd0, burst_read}, 64'd0);
    tick();
    #1;
    chk("t4_end_write", {63'd0, addr_write}, 64'd0);

    // 5: address wrap-around
    burst_dout = {8'd1, 64'hFFFF_FFFF_FFFF_FFC0}; burst_empty_n = 1'b1;
    tick();
    burst_empty_n = 1'b0;
    #1;
    chk("t5_b0_addr", addr_din, 64'hFFFF_FFFF_FFFF_FFC0);
    tick();
    #1;
    chk("t5_b1_addr", addr_din, 64'h0);
    chk("t5_b1_write", {63'd0, addr_write}, 64'd1);
    tick();

    // Max-length burst: 256 beats, bounded by a cycle budget
    burst_dout = {8'hFF, 64'h0}; burst_empty_n = 1'b1;
    tick();
    burst_empty_n = 1'b0;
    nwr = 0; exp_addr = 64'h0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (addr_write) begin
        if (addr_din !== exp_addr) chk("tmax_addr", addr_din, exp_addr);
        exp_addr = exp_addr + 64'h40;
        nwr++;
      end
      tick();
    end
    chk("tmax_count", 64'(nwr), 64'd256);

    // 6: reset in the middle of an 8-beat burst
    burst_dout = {8'd7, 64'h0}; burst_empty_n = 1'b1;
    tick();
    burst_empty_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_addr", addr_din, 64'(i) * 64'h40);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("t6_rst_write", {63'd0, addr_write}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rst_addr", addr_din, 64'h0);
    for (int i = 0; i < 5; i++) begin
      chk("t6_idle_write", {63'd0, addr_write}, 64'd0);
      chk("t6_idle_read", {63'd0, burst_read}, 64'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/burst_expand.md
Name: burst_expand

Overview:
Inverse of the address-stream burst detector. Pops burst descriptors {burst_len, base_addr} from an input FIFO and emits one beat address per cycle into an output FIFO. A descriptor expands to burst_len+1 addresses spaced 2^DataWidthBytesLog bytes apart. Used where a burst-granular request stream must be replayed as per-beat addresses, e.g. to feed per-element response or data routing.

Parameters:
AddrWidth, 64, byte-address width.
DataWidthBytesLog, 6, log2 of beat size in bytes; the address stride is 1<<DataWidthBytesLog.
BurstLenWidth, 8, width of the burst_len field; burst_len = beats-1.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
burst_dout  input  BurstLenWidth+AddrWidth  descriptor; [AddrWidth-1:0]=base_addr, upper bits=burst_len
burst_empty_n  input  1  descriptor FIFO non-empty
burst_read  output  1  pop descriptor
addr_din  output  AddrWidth  beat address
addr_full_n  input  1  address FIFO not full
addr_write  output  1  push beat address
addr_last  output  1  final beat of burst (only with BURST_EXPAND_LAST_EN)

Behaviour:
- State registers: state {IDLE, EMIT}, cur_addr[AddrWidth], remaining[BurstLenWidth].
- Reset: state=IDLE, cur_addr=0, remaining=0. burst_read=0 and addr_write=0 in the cycle after rst is sampled high.
- addr_din = cur_addr. It is combinational from the register and stable while addr_write is low.
- IDLE: burst_read = burst_empty_n. On read: cur_addr<=base_addr, remaining<=burst_len, state<=EMIT. No write in IDLE.
- EMIT: addr_write = addr_full_n, with no combinational dependence on burst_empty_n.
  - On a write with remaining!=0: cur_addr <= cur_addr + (1<<DataWidthBytesLog), remaining <= remaining-1.
  - On a write with remaining==0 (last beat):
    - if burst_empty_n: burst_read=1 in the same cycle, load the new descriptor, stay in EMIT. Back-to-back bursts have no bubble.
    - else: state<=IDLE.
  - If addr_full_n=0: no write, no read, all registers hold.
- burst_read is never asserted in EMIT except on the last-beat write.
- Latency: first address is presented the cycle after burst_read. Throughput is 1 address/cycle when unstalled.
- Arithmetic: the address increment is modulo 2^AddrWidth; wrap-around is silent. remaining never underflows.
- burst_len=0 gives exactly one beat. burst_len=2^BurstLenWidth-1 gives 2^BurstLenWidth beats.
- Reset mid-burst: the in-flight descriptor is discarded and state returns to IDLE. Beats already written remain valid downstream.
- No combinational path from addr_full_n to burst_read except through the last-beat condition above.

Optional Feature:
BURST_EXPAND_LAST_EN
- Defined: the addr_last port exists. addr_last = (state==EMIT && remaining==0), qualified by the consumer with addr_write. It resets to 0.
- Undefined: the port is absent and no logic is generated for it. All other behaviour is identical.

Test Plan:
1. Single burst: burst_dout={len=3, base=0x1000}, full_n=1 -> burst_read for 1 cycle; addr_din 0x1000, 0x1040, 0x1080, 0x10C0 on 4 consecutive addr_write cycles; addr_last on 0x10C0 only; then IDLE.
2. Single beat: {len=0, base=0x2000} -> exactly one write of 0x2000, addr_last=1; second write absent.
3. Backpressure: {len=2, base=0x0}, addr_full_n=0 for 2 cycles after first beat -> addr_write=0 and addr_din held at 0x40 during the stall; sequence 0x0, 0x40, 0x80 with no skip or duplicate.
4. Back-to-back: {1, 0x100} then {0, 0x800} queued -> writes 0x100, 0x140, 0x800 on 3 consecutive cycles; second burst_read coincides with the 0x140 write.
5. Wrap: {len=1, base=0xFFFFFFFFFFFFFFC0} -> 0xFFFFFFFFFFFFFFC0 then 0x0000000000000000.
6. Reset mid-burst: {len=7, base=0x0}, assert rst after 3 beats -> no writes after reset; after release with an empty input FIFO, burst_read=0 and addr_write=0 indefinitely.
